alu_share_ctrl: RTL and testbench



---
 rtl/alu_share_ctrl.sv | 125 ++++++++++++
 tb/tb_alu_share_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// Shares one combinational NOR/ROR ALU between two requesters; registers operands and captures results.
// Round-robin tie-break by default; define ALU_FIXED_PRIO_EN for fixed priority to port 0.
module alu_share_ctrl #(
  parameter int WIDTH   = 7,
  parameter int ALU_LAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cf,
  input  logic             alu_sf,
  input  logic             alu_zf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_cf,
  output logic             rsp_sf,
  output logic             rsp_zf
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  localparam logic [1:0] LAT = 2'(ALU_LAT);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] cnt;
  logic       pick1;
  logic       any_req;
  logic       cnt_done;

`ifdef ALU_FIXED_PRIO_EN
  assign pick1 = req1_valid & ~req0_valid;
`else
  logic last_grant;
  // On a tie the port that did not win last time goes next.
  assign pick1 = req1_valid & (~req0_valid | ~last_grant);
`endif

  assign any_req  = req0_valid | req1_valid;
  assign cnt_done = (cnt == LAT);

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = req0_valid & ~pick1;
        req1_ready = pick1;
        if (any_req) state_nxt = EXEC;
      end
      EXEC: if (cnt_done) state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= 1'b0;
      cnt        <= 2'd0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_cf     <= 1'b0;
      rsp_sf     <= 1'b0;
      rsp_zf     <= 1'b0;
`ifndef ALU_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            alu_a  <= pick1 ? req1_a  : req0_a;
            alu_b  <= pick1 ? req1_b  : req0_b;
            alu_op <= pick1 ? req1_op : req0_op;
            rsp_id <= pick1;
            cnt    <= 2'd0;
`ifndef ALU_FIXED_PRIO_EN
            last_grant <= pick1;
`endif
          end
        end
        EXEC: begin
          if (cnt_done) begin
            // Flags are passed through exactly as the ALU reports them.
            rsp_result <= alu_result;
            rsp_cf     <= alu_cf;
            rsp_sf     <= alu_sf;
            rsp_zf     <= alu_zf;
            rsp_valid  <= 1'b1;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: behavioural ALU plus transaction-level arbitration/result model.
module tb_alu_share_ctrl;
  localparam int W   = 7;
  localparam int LAT = 0;

  logic         clk, rst_n;
  logic         req0_valid, req0_ready, req0_op;
  logic         req1_valid, req1_ready, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic         alu_op, alu_cf, alu_sf, alu_zf;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_cf, rsp_sf, rsp_zf;
  logic [W-1:0] rsp_result;

  alu_share_ctrl #(.WIDTH(W), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_cf(alu_cf), .alu_sf(alu_sf), .alu_zf(alu_zf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_cf(rsp_cf), .rsp_sf(rsp_sf), .rsp_zf(rsp_zf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: ROR one bit at a time, CF driven from cf_drive.
  logic cf_drive;
  logic [W-1:0] rot;
  always_comb begin
    rot = alu_a;
    for (int i = 0; i < 7; i++)
      if (i < int'(alu_b[2:0])) rot = {rot[0], rot[W-1:1]};
    alu_result = alu_op ? rot : ~(alu_a | alu_b);
    alu_cf = cf_drive;
    alu_sf = alu_result[W-1];
    alu_zf = (alu_result == '0);
  end

  int errors = 0;
  int checks = 0;

  logic [W-1:0] a_q [2];
  logic [W-1:0] b_q [2];
  bit           op_q[2];
  bit           pend[2];
  bit           model_last;
  logic [W-1:0] obs_res;
  logic         obs_id, obs_sf, obs_zf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b, input bit op);
    logic [2*W-1:0] dbl;
    int k;
    if (!op) return ~(a | b);
    k = int'(b[2:0]) % W;
    dbl = {a, a} >> k;
    return dbl[W-1:0];
  endfunction

  task automatic set_req(input int p, input logic [W-1:0] a, input logic [W-1:0] b, input bit op);
    a_q[p] = a; b_q[p] = b; op_q[p] = op; pend[p] = 1'b1;
  endtask

  task automatic drive_reqs();
    req0_valid = pend[0]; req0_a = a_q[0]; req0_b = b_q[0]; req0_op = op_q[0];
    req1_valid = pend[1]; req1_a = a_q[1]; req1_b = b_q[1]; req1_op = op_q[1];
  endtask

  // Entered 1ns after a clock edge with the DUT idle; leaves it idle 1ns after an edge.
  task automatic txn(input int stall);
    bit w;
    logic [W-1:0] er;
    drive_reqs();
    #1;
`ifdef ALU_FIXED_PRIO_EN
    w = pend[1] && !pend[0];
`else
    w = (pend[0] && pend[1]) ? !model_last : pend[1];
`endif
    chk("ready0", 32'(req0_ready), 32'(w == 1'b0));
    chk("ready1", 32'(req1_ready), 32'(w == 1'b1));
    er = ref_res(a_q[w], b_q[w], op_q[w]);
    @(posedge clk); #1;
    model_last = w;
    pend[w] = 1'b0;
    drive_reqs();
    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("alu_a", 32'(alu_a), 32'(a_q[w]));
    chk("alu_b", 32'(alu_b), 32'(b_q[w]));
    chk("alu_op", 32'(alu_op), 32'(op_q[w]));
    chk("exec_ready", 32'({req0_ready, req1_ready}), 32'd0);
    repeat (LAT) begin
      @(posedge clk); #1;
      chk("wait_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_id", 32'(rsp_id), 32'(w));
    chk("rsp_result", 32'(rsp_result), 32'(er));
    chk("rsp_cf", 32'(rsp_cf), 32'(cf_drive));
    chk("rsp_sf", 32'(rsp_sf), 32'(er[W-1]));
    chk("rsp_zf", 32'(rsp_zf), 32'(er == '0));
    obs_res = rsp_result; obs_id = rsp_id; obs_sf = rsp_sf; obs_zf = rsp_zf;
    repeat (stall) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_result", 32'(rsp_result), 32'(obs_res));
      chk("bp_id", 32'(rsp_id), 32'(obs_id));
      chk("bp_ready", 32'({req0_ready, req1_ready}), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_done", 32'(rsp_valid), 32'd0);
    chk("alu_hold", 32'(alu_a), 32'(a_q[w]));
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0; cf_drive = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0; model_last = 1'b1;
    for (int p = 0; p < 2; p++) begin a_q[p] = '0; b_q[p] = '0; op_q[p] = 1'b0; end
    drive_reqs();
    #12;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
    chk("rst_rsp", 32'({rsp_id, rsp_result, rsp_cf, rsp_sf, rsp_zf}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // NOR of zeros
    set_req(0, 7'h00, 7'h00, 1'b0);
    txn(0);
    chk("t2_result", 32'(obs_res), 32'h7F);
    chk("t2_sf", 32'(obs_sf), 32'd1);
    chk("t2_id", 32'(obs_id), 32'd0);

    set_req(0, 7'h7F, 7'h00, 1'b0);
    txn(0);
    chk("t3_zero", 32'(obs_res), 32'h00);
    chk("t3_zf", 32'(obs_zf), 32'd1);
    set_req(0, 7'b0000001, 7'h01, 1'b1);
    txn(0);
    chk("t3_ror", 32'(obs_res), 32'h40);
    chk("t3_ror_sf", 32'(obs_sf), 32'd1);

    // CF is copied from the ALU, not recomputed
    cf_drive = 1'b1;
    set_req(1, 7'h15, 7'h0B, 1'b1);
    txn(0);
    cf_drive = 1'b0;

    // Reset while a response is pending
    set_req(1, 7'h2A, 7'h03, 1'b1);
    drive_reqs();
    @(posedge clk); #1;
    pend[1] = 1'b0;
    drive_reqs();
    @(posedge clk); #1;
    chk("t1_pre_valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t1_async_valid", 32'(rsp_valid), 32'd0);
    chk("t1_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
    chk("t1_rsp", 32'({rsp_id, rsp_result, rsp_cf, rsp_sf, rsp_zf}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_last = 1'b1;
    @(posedge clk); #1;

    // Both ports valid continuously
    set_req(0, 7'h11, 7'h22, 1'b0);
    set_req(1, 7'h33, 7'h05, 1'b1);
    for (int i = 0; i < 4; i++) begin
      txn(0);
`ifdef ALU_FIXED_PRIO_EN
      chk("t6_order", 32'(obs_id), 32'd0);
`else
      chk("t4_order", 32'(obs_id), 32'(i % 2));
`endif
      set_req(int'(obs_id), 7'($urandom), 7'($urandom), 1'($urandom));
    end

    // Backpressure
    txn(5);

    // Randomised traffic
    for (int n = 0; n < 60; n++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p] && $urandom_range(0, 2) != 0)
          set_req(p, 7'($urandom), 7'($urandom), 1'($urandom));
      if (!pend[0] && !pend[1])
        set_req(int'($urandom_range(0, 1)), 7'($urandom), 7'($urandom), 1'($urandom));
      cf_drive = 1'($urandom);
      txn(int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
